instr_loader: RTL and testbench
===============================

# instr_loader

Program-loading block that sits directly upstream of the instruction-fetch stage. It takes a byte stream from the UART receiver, assembles little-endian 32-bit instructions, and writes them sequentially into the fetch stage's instruction memory through that stage's write port (write enable, write address, write data). While loading, it holds the pipeline halted. It signals completion when it writes the end-of-program word, and signals an error if the program overflows memory.

## Interface
- NB_ADDR, 8, instruction-memory byte-address width; capacity = 2^NB_ADDR/4 words (64 by default)
- END_INSTR, 32'hFFFF_FFFF, end-of-program marker word; it is written to memory, then loading stops
- clk  input  1  single clock; all state updates on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  one-cycle pulse; begins a load; honoured only in IDLE, DONE or ERROR
- i_rx_data  input  8  received byte
- i_rx_valid  input  1  one-cycle strobe per received byte
- o_we  output  1  instruction-memory write enable, one cycle per word
- o_inst_addr  output  32  byte write address; multiple of 4; upper 32-NB_ADDR bits always 0
- o_instr_data  output  32  assembled instruction word
- o_cpu_halt  output  1  pipeline halt request
- o_busy  output  1  high in RECV and WRITE
- o_done  output  1  sticky; high in DONE
- o_error  output  1  sticky; high in ERROR (capacity overflow)
- o_word_count  output  NB_ADDR-1  number of words written in the current load, END_INSTR included

## Operation
- States: IDLE, RECV, WRITE, DONE, ERROR. Reset enters IDLE.
- All outputs are registered. Reset value of every output is 0.
- IDLE/DONE/ERROR:
  - i_start clears the byte counter, the address (0) and o_word_count, and clears o_done/o_error.
  - Then → RECV.
  - i_rx_valid is ignored in these states.
- RECV:
  - Each i_rx_valid stores i_rx_data into byte lane [byte_cnt] (byte 0 → bits 7:0), then increments byte_cnt (2 bits).
  - On the 4th byte (byte_cnt==3), the completed word is loaded into o_instr_data and the state → WRITE.
  - i_start is ignored.
- WRITE (exactly one cycle):
  - o_we=1, o_inst_addr=current address, o_instr_data=word; o_word_count increments at the end of the cycle.
  - Next state:
    - word==END_INSTR → DONE;
    - otherwise, o_word_count reaches capacity → ERROR;
    - otherwise → RECV, with address += 4.
  - An i_rx_valid arriving during WRITE is accepted as byte 0 of the next word, unless the next state is DONE or ERROR, in which case it is discarded.
- o_cpu_halt is 1 in RECV, WRITE and ERROR, and 0 in IDLE and DONE. After reset the pipeline is therefore free-running until a load starts.
- Address arithmetic: a 32-bit add, masked to NB_ADDR bits. ERROR is raised before any wrap, so addresses never alias.
- Asynchronous reset mid-load discards the partial word and all counters immediately. Memory contents already written are untouched.

## Timing
- Write latency: 4th-byte strobe sampled at edge N → o_we high in the cycle following edge N. o_we falls after edge N+1.
- i_start sampled at edge N → o_busy and o_cpu_halt high after edge N; o_done/o_error low after edge N.
- DONE/ERROR entered at the edge ending the WRITE cycle. o_cpu_halt drops at the same edge when entering DONE.
- Minimum byte spacing: one strobe per cycle is legal, including back-to-back strobes.
- o_we is never high for two consecutive cycles.

## Test plan
- Single word plus end:
  - Stimulus: i_start, then bytes 13 00 08 20 then FF FF FF FF.
  - Required: two writes, addr 0 data 32'h2008_0013, then addr 4 data 32'hFFFF_FFFF.
  - Then o_done=1, o_word_count=2, o_cpu_halt=0.
- Back-to-back strobes:
  - Stimulus: 8 bytes on consecutive cycles.
  - Required: the 5th byte arrives in the WRITE cycle and is captured. Second word correct at addr 4; o_we pulses exactly one cycle each.
- Overflow:
  - Stimulus: 64 non-END words (NB_ADDR=8).
  - Required: the 64th write goes to addr 252. Then o_error=1, o_cpu_halt=1, no further o_we.
  - Then i_start restarts from addr 0 with o_error=0.
- Reset mid-word:
  - Stimulus: deassert i_rst_n asynchronously after 2 bytes.
  - Required: all outputs 0 immediately without a clock edge.
  - Then, after a new i_start and 4 bytes AA BB CC DD, write addr 0 data 32'hDDCC_BBAA.
- Ignored inputs:
  - i_rx_valid in IDLE produces no write and byte_cnt stays 0.
  - i_start during RECV does not reset the address or byte_cnt.
- Reload after DONE:
  - Stimulus: a second i_start.
  - Required: o_done clears, o_word_count=0, and the first write goes to addr 0.

Source files
------------

// File: rtl/instr_loader.sv
// Program loader: assembles little-endian 32-bit words from a UART byte stream and
// writes them sequentially into instruction memory while the pipeline is held.

module instr_loader_lane #(
   parameter int VEC_W = 8
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic             i_we,
   input  logic [VEC_W-1:0] i_d,
   output logic [VEC_W-1:0] o_q
);
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)  o_q <= '0;
      else if (i_we) o_q <= i_d;
   end
endmodule

module instr_loader #(
   parameter int          NB_ADDR   = 8,
   parameter logic [31:0] END_INSTR = 32'hFFFF_FFFF
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic               o_we,
   output logic [31:0]        o_inst_addr,
   output logic [31:0]        o_instr_data,
   output logic               o_cpu_halt,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error,
   output logic [NB_ADDR-2:0] o_word_count
);
   localparam int                 NUM_LANES = 4;
   localparam int                 VEC_W     = 8;
   localparam int                 CAP       = (2**NB_ADDR) / 4;
   localparam logic [NB_ADDR-2:0] CAP_CNT   = (NB_ADDR-1)'(CAP);
   localparam logic [NB_ADDR-2:0] WC_ONE    = (NB_ADDR-1)'(1);
   localparam logic [31:0]        ADDR_MASK = 32'((64'd1 << NB_ADDR) - 64'd1);

   typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;

   state_t                          state, state_nxt;
   logic [1:0]                      byte_cnt;
   logic                            accept, start_load;
   logic                            we_d, busy_d, halt_d, done_d, err_d;
   logic [NB_ADDR-2:0]              wc_inc;
   logic [31:0]                     addr_inc;
   logic [NUM_LANES-2:0]            lane_we;
   logic [NUM_LANES-2:0][VEC_W-1:0] lane_q;

   assign wc_inc   = o_word_count + WC_ONE;
   assign addr_inc = (o_inst_addr + 32'd4) & ADDR_MASK;

   // Lanes 0..2 hold the partial word; the top byte goes straight into o_instr_data.
   for (genvar i = 0; i < NUM_LANES-1; i++) begin : g_lane
      assign lane_we[i] = accept && (byte_cnt == 2'(i));
      instr_loader_lane #(.VEC_W(VEC_W)) u_lane (
         .clk     (clk),
         .i_rst_n (i_rst_n),
         .i_we    (lane_we[i]),
         .i_d     (i_rx_data),
         .o_q     (lane_q[i])
      );
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      start_load = 1'b0;
      case (state)
         IDLE, DONE, ERROR: begin
            if (i_start) begin
               state_nxt  = RECV;
               start_load = 1'b1;
            end
         end
         RECV: begin
            if (i_rx_valid) begin
               accept = 1'b1;
               if (byte_cnt == 2'd3) state_nxt = WRITE;
            end
         end
         WRITE: begin
            // A byte landing in this cycle only counts if loading continues.
            if (o_instr_data == END_INSTR)  state_nxt = DONE;
            else if (wc_inc == CAP_CNT)     state_nxt = ERROR;
            else begin
               state_nxt = RECV;
               accept    = i_rx_valid;
            end
         end
         default: state_nxt = IDLE;
      endcase

      we_d   = (state_nxt == WRITE);
      busy_d = (state_nxt == RECV) || (state_nxt == WRITE);
      halt_d = busy_d || (state_nxt == ERROR);
      done_d = (state_nxt == DONE);
      err_d  = (state_nxt == ERROR);
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         byte_cnt     <= '0;
         o_we         <= 1'b0;
         o_busy       <= 1'b0;
         o_cpu_halt   <= 1'b0;
         o_done       <= 1'b0;
         o_error      <= 1'b0;
         o_inst_addr  <= '0;
         o_instr_data <= '0;
         o_word_count <= '0;
      end else begin
         o_we       <= we_d;
         o_busy     <= busy_d;
         o_cpu_halt <= halt_d;
         o_done     <= done_d;
         o_error    <= err_d;
         if (start_load) begin
            byte_cnt     <= '0;
            o_inst_addr  <= '0;
            o_word_count <= '0;
         end else begin
            if (accept) byte_cnt <= byte_cnt + 2'd1;
            if (accept && byte_cnt == 2'd3)
               o_instr_data <= {i_rx_data, lane_q};
            if (state == WRITE) begin
               o_word_count <= wc_inc;
               if (state_nxt == RECV) o_inst_addr <= addr_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed vector table, hand-written corner sequences and
// randomized loads checked against a byte-stream reference model.

module tb_instr_loader;
   localparam int          NB_ADDR = 8;
   localparam int          CAP     = 64;
   localparam logic [31:0] END_W   = 32'hFFFF_FFFF;

   logic               clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_rx_valid = 1'b0;
   logic [7:0]         i_rx_data = 8'h00;
   logic               o_we, o_cpu_halt, o_busy, o_done, o_error;
   logic [31:0]        o_inst_addr, o_instr_data;
   logic [NB_ADDR-2:0] o_word_count;

   int n_cmp = 0, n_err = 0;

   typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
   wr_t  wr_q[$];
   logic prev_we = 1'b0;

   typedef struct packed { logic [7:0] b0, b1, b2, b3; logic [31:0] exp; } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   instr_loader #(.NB_ADDR(NB_ADDR), .END_INSTR(END_W)) dut (
      .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_rx_data(i_rx_data),
      .i_rx_valid(i_rx_valid), .o_we(o_we), .o_inst_addr(o_inst_addr),
      .o_instr_data(o_instr_data), .o_cpu_halt(o_cpu_halt), .o_busy(o_busy),
      .o_done(o_done), .o_error(o_error), .o_word_count(o_word_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Write monitor: capture every write, check single-cycle pulses and address range.
   always @(negedge clk) begin
      if (o_we) begin
         wr_q.push_back({o_inst_addr, o_instr_data});
         chk("we_pulse", {31'd0, prev_we}, 32'd0);
         chk("addr_range", o_inst_addr & ~32'hFC, 32'd0);
      end
      prev_we = o_we;
   end

   task automatic put_byte(input logic [7:0] b, input int gap);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      @(negedge clk);
      i_rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic put_word(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) put_byte(w[8*k +: 8], gap);
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic expect_write(input string name, input logic [31:0] ea, input logic [31:0] ed);
      wr_t w;
      int  t;
      t = 0;
      while (wr_q.size() == 0 && t < 8) begin
         @(negedge clk);
         t++;
      end
      if (wr_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: no write seen, expected addr %h data %h", name, ea, ed);
      end else begin
         w = wr_q.pop_front();
         chk({name, "_addr"}, w.addr, ea);
         chk({name, "_data"}, w.data, ed);
      end
   endtask

   task automatic chk_status(input string name, input logic busy, input logic halt,
                             input logic done, input logic err, input int wc);
      chk({name, "_busy"}, {31'd0, o_busy}, {31'd0, busy});
      chk({name, "_halt"}, {31'd0, o_cpu_halt}, {31'd0, halt});
      chk({name, "_done"}, {31'd0, o_done}, {31'd0, done});
      chk({name, "_err"}, {31'd0, o_error}, {31'd0, err});
      chk({name, "_wc"}, {25'd0, o_word_count}, 32'(wc));
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_we"}, {31'd0, o_we}, 32'd0);
      chk({name, "_addr"}, o_inst_addr, 32'd0);
      chk({name, "_data"}, o_instr_data, 32'd0);
      chk_status(name, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  bq[$];
      logic [31:0] exp_w[$];
      logic [31:0] w;
      int          nw;

      tbl[0] = '{8'h13, 8'h00, 8'h08, 8'h20, 32'h2008_0013};
      tbl[1] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hDDCC_BBAA};
      tbl[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h0403_0201};
      tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000};
      tbl[4] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFE};
      tbl[5] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 32'h7FFF_FFFF};

      // Reset state
      #1;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      i_rst_n = 1'b1;
      @(negedge clk);

      // Bytes in IDLE are ignored
      put_byte(8'h55, 0);
      put_byte(8'h66, 1);
      repeat (2) @(negedge clk);
      chk("idle_nowr", 32'(wr_q.size()), 32'd0);
      chk_status("idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Single word plus end
      pulse_start();
      chk_status("start", 1'b1, 1'b1, 1'b0, 1'b0, 0);
      put_byte(8'h13, 1); put_byte(8'h00, 1); put_byte(8'h08, 1); put_byte(8'h20, 1);
      expect_write("w1", 32'd0, 32'h2008_0013);
      put_word(END_W, 1);
      expect_write("w1_end", 32'd4, END_W);
      repeat (2) @(negedge clk);
      chk_status("w1_done", 1'b0, 1'b0, 1'b1, 1'b0, 2);

      // Vector table load
      pulse_start();
      chk_status("tbl_start", 1'b1, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 6; i++) begin
         put_byte(tbl[i].b0, i % 2); put_byte(tbl[i].b1, i % 2);
         put_byte(tbl[i].b2, i % 2); put_byte(tbl[i].b3, i % 2);
         expect_write("tbl", 32'(4 * i), tbl[i].exp);
      end
      put_word(END_W, 0);
      expect_write("tbl_end", 32'd24, END_W);
      repeat (2) @(negedge clk);
      chk_status("tbl_done", 1'b0, 1'b0, 1'b1, 1'b0, 7);

      // Reload after DONE with back-to-back strobes, then i_start during RECV
      pulse_start();
      chk_status("reload", 1'b1, 1'b1, 1'b0, 1'b0, 0);
      for (int k = 1; k <= 8; k++) put_byte(8'(k), 0);
      expect_write("b2b0", 32'd0, 32'h0403_0201);
      expect_write("b2b1", 32'd4, 32'h0807_0605);
      put_byte(8'h11, 0); put_byte(8'h22, 1);
      pulse_start();
      put_byte(8'h33, 1); put_byte(8'h44, 1);
      expect_write("rstart", 32'd8, 32'h4433_2211);
      put_word(END_W, 0);
      put_byte(8'h99, 0);
      expect_write("rstart_end", 32'd12, END_W);
      repeat (3) @(negedge clk);
      chk("stray_nowr", 32'(wr_q.size()), 32'd0);
      chk_status("rstart_done", 1'b0, 1'b0, 1'b1, 1'b0, 4);

      // Asynchronous reset mid-word
      pulse_start();
      put_word(32'h1234_5678, 0);
      expect_write("pre_rst", 32'd0, 32'h1234_5678);
      put_byte(8'h01, 1); put_byte(8'h02, 1);
      #2 i_rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      @(negedge clk);
      i_rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      put_byte(8'hAA, 0); put_byte(8'hBB, 0); put_byte(8'hCC, 0); put_byte(8'hDD, 0);
      expect_write("post_rst", 32'd0, 32'hDDCC_BBAA);
      put_word(END_W, 1);
      expect_write("post_rst_end", 32'd4, END_W);

      // Capacity overflow
      repeat (2) @(negedge clk);
      pulse_start();
      for (int i = 0; i < CAP; i++) begin
         w = $urandom;
         if (w == END_W) w = 32'h0;
         put_word(w, $urandom_range(0, 1));
         expect_write("ovf", 32'(4 * i), w);
      end
      repeat (2) @(negedge clk);
      chk_status("ovf", 1'b0, 1'b1, 1'b0, 1'b1, 64);
      put_word(32'h0BAD_0BAD, 0);
      repeat (3) @(negedge clk);
      chk("ovf_nowr", 32'(wr_q.size()), 32'd0);
      pulse_start();
      chk_status("ovf_restart", 1'b1, 1'b1, 1'b0, 1'b0, 0);
      put_word(32'hCAFE_F00D, 0);
      expect_write("ovf_restart", 32'd0, 32'hCAFE_F00D);
      put_word(END_W, 0);
      expect_write("ovf_restart_end", 32'd4, END_W);
      repeat (2) @(negedge clk);

      // Randomized loads against a byte-stream model
      for (int ld = 0; ld < 20; ld++) begin
         bq.delete();
         exp_w.delete();
         nw = $urandom_range(1, 10);
         for (int i = 0; i < nw; i++) begin
            w = (i == nw - 1 || $urandom_range(0, 5) == 0) ? END_W : $urandom;
            for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
         end
         repeat ($urandom_range(0, 3)) bq.push_back(8'($urandom));
         // Model: group bytes four at a time little-endian, stop at END or capacity
         for (int k = 0; k + 3 < bq.size() && exp_w.size() < CAP; k += 4) begin
            w = {bq[k+3], bq[k+2], bq[k+1], bq[k]};
            exp_w.push_back(w);
            if (w == END_W) break;
         end
         wr_q.delete();
         pulse_start();
         foreach (bq[k]) put_byte(bq[k], $urandom_range(0, 2));
         repeat (4) @(negedge clk);
         chk("rnd_nwr", 32'(wr_q.size()), 32'(exp_w.size()));
         for (int k = 0; k < exp_w.size() && k < wr_q.size(); k++) begin
            chk("rnd_addr", wr_q[k].addr, 32'(4 * k));
            chk("rnd_data", wr_q[k].data, exp_w[k]);
         end
         chk_status("rnd", 1'b0, 1'b0, 1'b1, 1'b0, exp_w.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
